// File: rtl/axis_stream_xbar_pkg.sv
// Shared types and the round-robin selection helper for the AXI-Stream packet crossbar.
// Both the per-master arbiters and the crossbar top import this package.
package axis_stream_xbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } grant_state_e;

  // Widest request vector the helper accepts; callers zero-extend into it.
  localparam int MAX_REQ   = 32;
  localparam int MAX_REQ_W = $clog2(MAX_REQ);

  // Returns the first requester found scanning upward from ptr (wrapping at n), or -1 if none.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int idx;
    int pick;
    pick = -1;
    // Scan downward so the entry closest to ptr is written last and wins.
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx -= n;
        if (req[idx[MAX_REQ_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Per-master packet arbiter: registered round-robin grant held until the last beat is accepted.
// One instance serves each master output of the crossbar.
module axis_rr_arbiter
  import axis_stream_xbar_pkg::*;
#(
  parameter int N     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic             busy_o,
  output logic [IDX_W-1:0] grant_o
);

  grant_state_e     state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [MAX_REQ-1:0] req_ext;
  int               pick;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    req_ext          = '0;
    req_ext[N-1:0]   = req_i;
    pick             = rr_pick(req_ext, int'(ptr_q), N);
    state_d          = state_q;
    grant_d          = grant_q;
    ptr_d            = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick >= 0) begin
          state_d = BUSY;
          grant_d = IDX_W'(pick);
          ptr_d   = (pick == N - 1) ? '0 : IDX_W'(pick + 1);
        end
      end
      BUSY: begin
        if (done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign grant_o = grant_q;

endmodule

// File: rtl/axis_stream_xbar.sv
// S x M AXI-Stream packet crossbar: TDEST-routed, per-master round-robin, packet-atomic.
// Packets addressed past the last master are swallowed without producing output.
module axis_stream_xbar
  import axis_stream_xbar_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int S_DATA_COUNT = 10,
  parameter int M_DATA_COUNT = 10,
  localparam int ID_WIDTH    = $clog2(S_DATA_COUNT),
  localparam int DEST_WIDTH  = $clog2(M_DATA_COUNT),
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_data_i  [S_DATA_COUNT-1:0],
  input  logic [DEST_WIDTH-1:0]   s_axis_dest_i  [S_DATA_COUNT-1:0],
  input  logic [KEEP_WIDTH-1:0]   s_axis_keep_i  [S_DATA_COUNT-1:0],
  input  logic [S_DATA_COUNT-1:0] s_axis_last_i,
  input  logic [S_DATA_COUNT-1:0] s_axis_valid_i,
  output logic [S_DATA_COUNT-1:0] s_axis_ready_o,
  output logic [DATA_WIDTH-1:0]   m_axis_data_o  [M_DATA_COUNT-1:0],
  output logic [ID_WIDTH-1:0]     m_axis_id_o    [M_DATA_COUNT-1:0],
  output logic [KEEP_WIDTH-1:0]   m_axis_keep_o  [M_DATA_COUNT-1:0],
  output logic [M_DATA_COUNT-1:0] m_axis_last_o,
  output logic [M_DATA_COUNT-1:0] m_axis_valid_o,
  input  logic [M_DATA_COUNT-1:0] m_axis_ready_i
);

  logic [S_DATA_COUNT-1:0] req [M_DATA_COUNT];
  logic [ID_WIDTH-1:0]     grant [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] busy;
  logic [M_DATA_COUNT-1:0] done;
  logic                    active_q;

  // Holds drop-ready low until the first clock after reset releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[m][s] = s_axis_valid_i[s] && (int'(s_axis_dest_i[s]) == m);
      end
    end
  end

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_arb
    axis_rr_arbiter #(
      .N     (S_DATA_COUNT),
      .IDX_W (ID_WIDTH)
    ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (req[m]),
      .done_i  (done[m]),
      .busy_o  (busy[m]),
      .grant_o (grant[m])
    );
  end

  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      m_axis_valid_o[m] = 1'b0;
      m_axis_last_o[m]  = 1'b0;
      m_axis_data_o[m]  = '0;
      m_axis_keep_o[m]  = '0;
      m_axis_id_o[m]    = '0;
      if (busy[m]) begin
        m_axis_valid_o[m] = s_axis_valid_i[grant[m]];
        m_axis_last_o[m]  = s_axis_last_i[grant[m]];
        m_axis_data_o[m]  = s_axis_data_i[grant[m]];
        m_axis_keep_o[m]  = s_axis_keep_i[grant[m]];
        m_axis_id_o[m]    = grant[m];
      end
    end
  end

  assign done = m_axis_valid_o & m_axis_ready_i & m_axis_last_o;

  // A slave targets one master at a time, so at most one grant can drive each ready bit.
  always_comb begin
    s_axis_ready_o = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      if (busy[m] && m_axis_ready_i[m]) s_axis_ready_o[grant[m]] = 1'b1;
    end
    for (int s = 0; s < S_DATA_COUNT; s++) begin
      if (active_q && s_axis_valid_i[s] && (int'(s_axis_dest_i[s]) >= M_DATA_COUNT)) begin
        s_axis_ready_o[s] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_xbar.sv
// Directed bench for axis_stream_xbar: routing, arbitration order, backpressure, drop and reset.
// A negedge monitor logs every accepted master beat; tests compare the log against hand-built values.
module tb_axis_stream_xbar;

  localparam int DW = 64;
  localparam int S  = 10;
  localparam int M  = 10;
  localparam int IW = $clog2(S);
  localparam int DE = $clog2(M);
  localparam int KW = DW / 8;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] s_data  [S-1:0];
  logic [DE-1:0] s_dest  [S-1:0];
  logic [KW-1:0] s_keep  [S-1:0];
  logic [S-1:0]  s_last;
  logic [S-1:0]  s_valid;
  logic [S-1:0]  s_ready;
  logic [DW-1:0] m_data  [M-1:0];
  logic [IW-1:0] m_id    [M-1:0];
  logic [KW-1:0] m_keep  [M-1:0];
  logic [M-1:0]  m_last;
  logic [M-1:0]  m_valid;
  logic [M-1:0]  m_ready;

  axis_stream_xbar #(
    .DATA_WIDTH   (DW),
    .S_DATA_COUNT (S),
    .M_DATA_COUNT (M)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis_data_i  (s_data),
    .s_axis_dest_i  (s_dest),
    .s_axis_keep_i  (s_keep),
    .s_axis_last_i  (s_last),
    .s_axis_valid_i (s_valid),
    .s_axis_ready_o (s_ready),
    .m_axis_data_o  (m_data),
    .m_axis_id_o    (m_id),
    .m_axis_keep_o  (m_keep),
    .m_axis_last_o  (m_last),
    .m_axis_valid_o (m_valid),
    .m_axis_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    int          id;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t log_q[$];
  int    cyc;
  int    tests_run;
  int    tests_failed;
  logic  valid_seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int m = 0; m < M; m++) begin
      if (m_valid[m]) valid_seen = 1'b1;
      if (m_valid[m] && m_ready[m]) begin
        log_q.push_back('{m: m, id: int'(m_id[m]), data: m_data[m], keep: m_keep[m],
                          last: m_last[m], cyc: cyc});
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] meta(input int m, input int id, input logic [7:0] keep,
                                       input logic last);
    return (64'(m) << 16) | (64'(id) << 9) | (64'(keep) << 1) | 64'(last);
  endfunction

  // Compares the n-th logged beat of master m (in log order) against expected fields.
  task automatic check_beat(input string tag, input int m, input int n, input int id,
                            input logic [63:0] data, input logic [7:0] keep, input logic last);
    int k;
    int found;
    k = 0;
    found = -1;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].m == m) begin
        if (k == n) found = i;
        k++;
      end
    end
    if (found < 0) begin
      check({tag, "_present"}, 64'(k), 64'(n + 1));
    end else begin
      check({tag, "_data"}, log_q[found].data, data);
      check({tag, "_meta"}, meta(log_q[found].m, log_q[found].id, log_q[found].keep,
                                 log_q[found].last), meta(m, id, keep, last));
    end
  endtask

  function automatic int count_m(input int m);
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i].m == m) c++;
    return c;
  endfunction

  function automatic int cyc_of(input int m, input int n);
    int k;
    int c;
    k = 0;
    c = -1;
    foreach (log_q[i]) begin
      if (log_q[i].m == m) begin
        if (k == n) c = log_q[i].cyc;
        k++;
      end
    end
    return c;
  endfunction

  task automatic send_pkt(input int s, input int dest, input int n, input logic [63:0] base,
                          input logic [7:0] keep);
    logic accepted;
    for (int b = 0; b < n; b++) begin
      s_data[s]  = base + 64'(b);
      s_dest[s]  = DE'(dest);
      s_keep[s]  = keep;
      s_last[s]  = (b == n - 1);
      s_valid[s] = 1'b1;
      accepted   = 1'b0;
      for (int t = 0; t < 100 && !accepted; t++) begin
        @(negedge clk);
        if (s_ready[s]) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!accepted) check($sformatf("s%0d_accept_timeout", s), 64'(accepted), 64'd1);
    end
    s_valid[s] = 1'b0;
    s_last[s]  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int mirror_err;
  int c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    valid_seen   = 1'b0;
    reset_n      = 1'b0;
    s_valid      = '0;
    s_last       = '0;
    m_ready      = '1;
    for (int s = 0; s < S; s++) begin
      s_data[s] = '0;
      s_dest[s] = '0;
      s_keep[s] = '0;
    end

    // Reset state
    idle_cycles(3);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_id3", 64'(m_id[3]), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);

    // 1: single packet s0 -> m3
    log_q.delete();
    send_pkt(0, 3, 4, 64'h1, 8'hFF);
    idle_cycles(3);
    check("t1_count_all", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check_beat($sformatf("t1_b%0d", i), 3, i, 0, 64'(i + 1), 8'hFF, i == 3);

    // 2: s1 and s2 contend for m5; s1 wins first, no interleave
    log_q.delete();
    fork
      send_pkt(1, 5, 3, 64'h10, 8'hFF);
      send_pkt(2, 5, 3, 64'h20, 8'hFF);
    join
    idle_cycles(3);
    check("t2_count", 64'(count_m(5)), 64'd6);
    for (int i = 0; i < 3; i++)
      check_beat($sformatf("t2_s1_b%0d", i), 5, i, 1, 64'h10 + 64'(i), 8'hFF, i == 2);
    for (int i = 0; i < 3; i++)
      check_beat($sformatf("t2_s2_b%0d", i), 5, i + 3, 2, 64'h20 + 64'(i), 8'hFF, i == 2);

    // 3: m7 backpressure toggling every cycle
    log_q.delete();
    mirror_err = 0;
    fork
      send_pkt(4, 7, 6, 64'h40, 8'h3C);
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          m_ready[7] = ~m_ready[7];
          @(negedge clk);
          if (m_valid[7] && (s_ready[4] !== m_ready[7])) mirror_err++;
        end
      end
    join
    m_ready[7] = 1'b1;
    idle_cycles(2);
    check("t3_mirror_err", 64'(mirror_err), 64'd0);
    check("t3_count", 64'(count_m(7)), 64'd6);
    for (int i = 0; i < 6; i++)
      check_beat($sformatf("t3_b%0d", i), 7, i, 4, 64'h40 + 64'(i), 8'h3C, i == 5);

    // 4: two independent paths at full rate
    log_q.delete();
    fork
      send_pkt(0, 0, 8, 64'h100, 8'hFF);
      send_pkt(9, 9, 8, 64'h900, 8'h0F);
    join
    idle_cycles(2);
    check("t4_count_m0", 64'(count_m(0)), 64'd8);
    check("t4_count_m9", 64'(count_m(9)), 64'd8);
    check("t4_rate_m0", 64'(cyc_of(0, 7) - cyc_of(0, 0)), 64'd7);
    check("t4_rate_m9", 64'(cyc_of(9, 7) - cyc_of(9, 0)), 64'd7);
    check("t4_concurrent", 64'(cyc_of(9, 0) - cyc_of(0, 0)), 64'd0);
    check_beat("t4_m0_b7", 0, 7, 0, 64'h107, 8'hFF, 1'b1);
    check_beat("t4_m9_b0", 9, 0, 9, 64'h900, 8'h0F, 1'b0);

    // 5: invalid dest drops the packet, then a valid packet from the same source
    log_q.delete();
    valid_seen = 1'b0;
    c0 = cyc;
    send_pkt(3, 12, 3, 64'h30, 8'hFF);
    check("t5_drop_cycles", 64'(cyc - c0), 64'd3);
    idle_cycles(2);
    check("t5_no_valid", 64'(valid_seen), 64'd0);
    send_pkt(3, 2, 2, 64'h300, 8'hFF);
    idle_cycles(2);
    check("t5_count_m2", 64'(count_m(2)), 64'd2);
    check_beat("t5_b0", 2, 0, 3, 64'h300, 8'hFF, 1'b0);
    check_beat("t5_b1", 2, 1, 3, 64'h301, 8'hFF, 1'b1);

    // 6: asynchronous reset in the middle of a packet on m1
    s_data[5]  = 64'h55;
    s_dest[5]  = DE'(1);
    s_keep[5]  = 8'hFF;
    s_last[5]  = 1'b0;
    s_valid[5] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("t6_pre_valid", 64'(m_valid[1]), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 64'(m_valid), 64'd0);
    check("t6_rst_s_ready", 64'(s_ready), 64'd0);
    s_valid[5] = 1'b0;
    idle_cycles(2);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(1);
    log_q.delete();
    send_pkt(5, 1, 2, 64'h500, 8'hFF);
    idle_cycles(3);
    check("t6_count_m1", 64'(count_m(1)), 64'd2);
    check_beat("t6_b0", 1, 0, 5, 64'h500, 8'hFF, 1'b0);
    check_beat("t6_b1", 1, 1, 5, 64'h501, 8'hFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
